// File: rtl/pipe_sub_16bit.sv
// ---------------------------------------------------------------------------
// pipe_sub_16bit
//   Pipelined subtractor: d = (a - b - bin) mod 2^SIZE, with borrow-out and
//   signed-overflow flags. The subtraction is carried out as a + ~b + ~bin.
//   Each pipeline stage resolves CHUNK bits and hands its carry to the next
//   stage. A final output register presents the whole beat at once, which
//   gives a latency of NSTAGE cycles from acceptance to out_valid.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     a, b, bin  minuend, subtrahend, borrow in
//     in_valid   operand beat present
//     in_ready   block accepts a beat this cycle (combinational, == enable)
//     d          difference
//     bout       borrow out (1 when unsigned a < b + bin)
//     ovf        signed overflow
//     out_valid  result beat present
//     out_ready  downstream accepts the result
// ---------------------------------------------------------------------------
module pipe_sub_16bit #(
    parameter int SIZE  = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bin,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [SIZE-1:0] d,
    output logic            bout,
    output logic            ovf,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int NSTAGE = SIZE / CHUNK;
    localparam int LAST   = NSTAGE - 1;

    logic            en;
    logic [SIZE-1:0] d_q, d_d;
    logic            bout_q, bout_d;
    logic            ovf_q, ovf_d;
    logic            out_valid_q, out_valid_d;

    // The whole pipe stalls as one unit whenever a result is waiting and the
    // consumer is not taking it.
    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    function automatic logic [CHUNK:0] chunk_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             c
    );
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    genvar k;
    generate
        for (k = 0; k < NSTAGE; k++) begin : g_stg
            // RW: result bits already resolved after this stage.
            // OW: operand bits still waiting for later stages.
            localparam int RW = (k + 1) * CHUNK;
            localparam int OW = SIZE - RW;

            logic [CHUNK-1:0] a_c;
            logic [CHUNK-1:0] nb_c;
            logic             cin;
            logic             vld_in;
            logic [CHUNK:0]   sum;
            logic [RW-1:0]    res_new;

            logic [RW-1:0]    res_q, res_d;
            logic             cy_q, cy_d;
            logic             vld_q, vld_d;

            if (k == 0) begin : g_src
                assign a_c     = a[CHUNK-1:0];
                assign nb_c    = ~b[CHUNK-1:0];
                assign cin     = ~bin;
                assign vld_in  = in_valid;
                assign res_new = sum[CHUNK-1:0];
            end else begin : g_src
                assign a_c     = g_stg[k-1].g_op.opa_q[CHUNK-1:0];
                assign nb_c    = g_stg[k-1].g_op.opnb_q[CHUNK-1:0];
                assign cin     = g_stg[k-1].cy_q;
                assign vld_in  = g_stg[k-1].vld_q;
                // Lower chunks ride along behind so the beat stays aligned.
                assign res_new = {sum[CHUNK-1:0], g_stg[k-1].res_q};
            end

            assign sum = chunk_add(a_c, nb_c, cin);

            always_comb begin
                res_d = res_q;
                cy_d  = cy_q;
                vld_d = vld_q;
                if (en) begin
                    res_d = res_new;
                    cy_d  = sum[CHUNK];
                    vld_d = vld_in;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= vld_d;
                end
            end

            always_ff @(posedge clk) begin
                res_q <= res_d;
                cy_q  <= cy_d;
            end

            // Operand chunks not yet consumed are skew-delayed, stored shifted
            // down so that bit 0 is always the next stage's chunk.
            if (k < NSTAGE - 1) begin : g_op
                logic [OW-1:0] opa_in, opnb_in;
                logic [OW-1:0] opa_q, opa_d;
                logic [OW-1:0] opnb_q, opnb_d;

                if (k == 0) begin : g_op_src
                    assign opa_in  = a[SIZE-1:CHUNK];
                    assign opnb_in = ~b[SIZE-1:CHUNK];
                end else begin : g_op_src
                    assign opa_in  = g_stg[k-1].g_op.opa_q[OW+CHUNK-1:CHUNK];
                    assign opnb_in = g_stg[k-1].g_op.opnb_q[OW+CHUNK-1:CHUNK];
                end

                always_comb begin
                    opa_d  = opa_q;
                    opnb_d = opnb_q;
                    if (en) begin
                        opa_d  = opa_in;
                        opnb_d = opnb_in;
                    end
                end

                always_ff @(posedge clk) begin
                    opa_q  <= opa_d;
                    opnb_q <= opnb_d;
                end
            end

            // The top stage sees the operand sign bits (b's sign is the
            // complement of nb_c's msb), so overflow is resolved here:
            // signs of a and b differ and the result sign differs from a.
            if (k == NSTAGE - 1) begin : g_ovf
                logic ovf_new;
                logic ovf_q, ovf_d;

                assign ovf_new = (a_c[CHUNK-1] == nb_c[CHUNK-1]) &&
                                 (sum[CHUNK-1] != a_c[CHUNK-1]);

                always_comb begin
                    ovf_d = ovf_q;
                    if (en) begin
                        ovf_d = ovf_new;
                    end
                end

                always_ff @(posedge clk) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    endgenerate

    // Output register: loads only on valid beats so d/bout/ovf stay at their
    // reset value of zero until the first result arrives.
    always_comb begin
        d_d         = d_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (en) begin
            out_valid_d = g_stg[LAST].vld_q;
            if (g_stg[LAST].vld_q) begin
                d_d    = g_stg[LAST].res_q;
                bout_d = ~g_stg[LAST].cy_q;
                ovf_d  = g_stg[LAST].g_ovf.ovf_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q         <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            d_q         <= d_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign d         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipe_sub_16bit.sv
module tb_pipe_sub_16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    int checks;
    int errors;

    pipe_sub_16bit #(.SIZE(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: wide subtraction; bit 16 of the 17-bit result is the borrow.
    function automatic logic [17:0] ref_sub(input logic [15:0] x, input logic [15:0] y,
                                            input logic c);
        logic [16:0] r;
        logic        v;
        r = {1'b0, x} - {1'b0, y} - {16'd0, c};
        v = (x[15] != y[15]) && (r[15] != x[15]);
        return {v, r};
    endfunction

    // Drives one beat, then reports out_valid three edges after acceptance
    // (must still be low) and the outputs four edges after acceptance.
    task automatic send_one(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                            output logic early_vld, output logic vld,
                            output logic [15:0] dd, output logic bo, output logic ov);
        a = ai; b = bi; bin = ci; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        early_vld = out_valid;
        @(posedge clk); #1;
        vld = out_valid; dd = d; bo = bout; ov = ovf;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (d !== 16'h0 || bout !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got d=%h bout=%b ovf=%b want 0000 0 0", d, bout, ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic ev, v, bo, ov; logic [15:0] dd;
        send_one(16'h1234, 16'h0234, 1'b0, ev, v, dd, bo, ov);
        checks++;
        if (ev !== 1'b0) begin errors++; $display("FAIL basic_latency_early out_valid=%b want 0", ev); end
        checks++;
        if (v !== 1'b1 || dd !== 16'h1000 || bo !== 1'b0 || ov !== 1'b0) begin
            errors++; $display("FAIL basic got v=%b d=%h bout=%b ovf=%b want 1 1000 0 0", v, dd, bo, ov);
        end
    endtask

    task automatic test_wrap_borrow();
        logic ev, v, bo, ov; logic [15:0] dd;
        send_one(16'h0000, 16'h0001, 1'b0, ev, v, dd, bo, ov);
        checks++;
        if (v !== 1'b1 || dd !== 16'hFFFF || bo !== 1'b1 || ov !== 1'b0) begin
            errors++; $display("FAIL wrap got v=%b d=%h bout=%b ovf=%b want 1 ffff 1 0", v, dd, bo, ov);
        end
        send_one(16'h0005, 16'h0003, 1'b1, ev, v, dd, bo, ov);
        checks++;
        if (v !== 1'b1 || dd !== 16'h0001 || bo !== 1'b0 || ov !== 1'b0) begin
            errors++; $display("FAIL bin_used got v=%b d=%h bout=%b ovf=%b want 1 0001 0 0", v, dd, bo, ov);
        end
    endtask

    task automatic test_overflow();
        logic ev, v, bo, ov; logic [15:0] dd;
        send_one(16'h8000, 16'h0001, 1'b0, ev, v, dd, bo, ov);
        checks++;
        if (v !== 1'b1 || dd !== 16'h7FFF || bo !== 1'b0 || ov !== 1'b1) begin
            errors++; $display("FAIL ovf_neg got v=%b d=%h bout=%b ovf=%b want 1 7fff 0 1", v, dd, bo, ov);
        end
        send_one(16'h7FFF, 16'hFFFF, 1'b0, ev, v, dd, bo, ov);
        checks++;
        if (v !== 1'b1 || dd !== 16'h8000 || bo !== 1'b1 || ov !== 1'b1) begin
            errors++; $display("FAIL ovf_pos got v=%b d=%h bout=%b ovf=%b want 1 8000 1 1", v, dd, bo, ov);
        end
    endtask

    task automatic test_boundary();
        logic ev, v, bo, ov; logic [15:0] dd;
        send_one(16'hABCD, 16'hABCD, 1'b0, ev, v, dd, bo, ov);
        checks++;
        if (dd !== 16'h0000 || bo !== 1'b0 || ov !== 1'b0) begin
            errors++; $display("FAIL equal got d=%h bout=%b ovf=%b want 0000 0 0", dd, bo, ov);
        end
        send_one(16'h0000, 16'h0000, 1'b1, ev, v, dd, bo, ov);
        checks++;
        if (dd !== 16'hFFFF || bo !== 1'b1 || ov !== 1'b0) begin
            errors++; $display("FAIL zero_bin got d=%h bout=%b ovf=%b want ffff 1 0", dd, bo, ov);
        end
        send_one(16'h1234, 16'hFFFF, 1'b1, ev, v, dd, bo, ov);
        checks++;
        if (dd !== 16'h1234 || bo !== 1'b1 || ov !== 1'b0) begin
            errors++; $display("FAIL ones_bin_a got d=%h bout=%b ovf=%b want 1234 1 0", dd, bo, ov);
        end
        send_one(16'hFFFF, 16'hFFFF, 1'b1, ev, v, dd, bo, ov);
        checks++;
        if (dd !== 16'hFFFF || bo !== 1'b1 || ov !== 1'b0) begin
            errors++; $display("FAIL ones_bin_b got d=%h bout=%b ovf=%b want ffff 1 0", dd, bo, ov);
        end
    endtask

    // 64 back-to-back beats; beat j is accepted on edge j and must appear on
    // edge j+4, so out_valid is high on edges 4..67 and low otherwise.
    task automatic test_back_to_back();
        logic [17:0] expq[$];
        logic [17:0] e;
        logic [15:0] av, bv;
        logic        cv;
        logic        want_v;
        av = 16'h1357; bv = 16'h2468; cv = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 72; t++) begin
            if (t < 64) begin
                a = av; b = bv; bin = cv; in_valid = 1'b1;
                expq.push_back(ref_sub(av, bv, cv));
                av = av + 16'h0481; bv = bv + 16'h1021; cv = ~cv;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            want_v = (t >= 4) && (t <= 67);
            checks++;
            if (out_valid !== want_v) begin
                errors++; $display("FAIL b2b_valid edge %0d got %b want %b", t, out_valid, want_v);
            end
            if (out_valid === 1'b1 && want_v && expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (d !== e[15:0] || bout !== e[16] || ovf !== e[17]) begin
                    errors++;
                    $display("FAIL b2b_data edge %0d got d=%h bout=%b ovf=%b want d=%h bout=%b ovf=%b",
                             t, d, bout, ovf, e[15:0], e[16], e[17]);
                end
            end
        end
        checks++;
        if (expq.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", expq.size()); end
        @(posedge clk); #1;
    endtask

    // Stream with out_ready low for three cycles while outputs are valid.
    task automatic test_backpressure();
        logic [17:0] expq[$];
        logic [17:0] e;
        logic [15:0] sd;
        logic        sb, so, sv, acc, cons, stall;
        int          idx, got;
        idx = 0; got = 0;
        for (int t = 0; t < 40; t++) begin
            out_ready = !(t >= 6 && t < 9);
            if (idx < 10) begin
                a = 16'h0100 * idx[15:0] + 16'h0037;
                b = 16'h0011 * idx[15:0];
                bin = idx[0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc   = in_valid & in_ready;
            cons  = out_valid & out_ready;
            stall = out_valid & ~out_ready;
            sd = d; sb = bout; so = ovf; sv = out_valid;
            if (stall) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready t=%0d got %b want 0", t, in_ready); end
            end
            @(posedge clk); #1;
            if (acc) begin
                expq.push_back(ref_sub(a, b, bin));
                idx++;
            end
            if (stall) begin
                checks++;
                if (out_valid !== sv || d !== sd || bout !== sb || ovf !== so) begin
                    errors++;
                    $display("FAIL bp_hold t=%0d got v=%b d=%h bout=%b ovf=%b want v=%b d=%h bout=%b ovf=%b",
                             t, out_valid, d, bout, ovf, sv, sd, sb, so);
                end
            end
            if (cons) begin
                got++;
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL bp_extra t=%0d got unexpected beat d=%h want none", t, sd);
                end else begin
                    e = expq.pop_front();
                    if (sd !== e[15:0] || sb !== e[16] || so !== e[17]) begin
                        errors++;
                        $display("FAIL bp_data t=%0d got d=%h bout=%b ovf=%b want d=%h bout=%b ovf=%b",
                                 t, sd, sb, so, e[15:0], e[16], e[17]);
                    end
                end
            end
        end
        checks++;
        if (got != 10) begin errors++; $display("FAIL bp_count got %0d want 10", got); end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a = 16'h5000 + 16'(j); b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || d !== 16'h0) begin
            errors++; $display("FAIL midrst_clear got v=%b rdy=%b d=%h want 0 1 0000", out_valid, in_ready, d);
        end
        #2 rst_n = 1'b1;
        a = 16'h0010; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== (t == 4)) begin
                errors++; $display("FAIL midrst_valid edge %0d got %b want %b", t, out_valid, (t == 4));
            end
            if (t == 4) begin
                checks++;
                if (d !== 16'h000F || bout !== 1'b0 || ovf !== 1'b0) begin
                    errors++; $display("FAIL midrst_data got d=%h bout=%b ovf=%b want 000f 0 0", d, bout, ovf);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_wrap_borrow();
        test_overflow();
        test_boundary();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_sub_16bit.md
Name: pipe_sub_16bit

Overview:
- Pipelined 16-bit unsigned/two's-complement subtractor: D = A - B - BIN, with borrow-out and signed overflow flags.
- Companion to the ripple-carry adder. The adder produces sums; this block undoes them, e.g. for adder self-check loops and difference paths.
- Borrow propagates through CHUNK-bit slices with one register stage per slice.
- Valid/ready streaming handshake with backpressure.

Parameters:
- SIZE, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; NSTAGE = SIZE/CHUNK (default 4).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  SIZE  minuend
- b  input  SIZE  subtrahend
- bin  input  1  borrow in
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts a beat this cycle
- d  output  SIZE  difference
- bout  output  1  borrow out
- ovf  output  1  signed overflow
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result

Behaviour:
- Arithmetic: d = (a - b - bin) mod 2^SIZE.
  - Implemented as a + ~b + ~bin, so carry-in = ~bin and bout = ~carry_out.
  - bout=1 iff unsigned a < b + bin.
  - ovf=1 iff a[SIZE-1] != b[SIZE-1] and d[SIZE-1] != a[SIZE-1].
- Pipeline structure:
  - Stage k (0..NSTAGE-1) computes chunk k from the operand chunk and the carry registered by stage k-1.
  - Stage 0 uses ~bin.
  - Upper operand chunks are skew-delayed; lower result chunks are de-skew-delayed so all chunks of a beat exit together.
- Latency: exactly NSTAGE cycles from an accepted beat (in_valid & in_ready at edge t) to out_valid at edge t+NSTAGE, provided there is no stall.
- Global enable: en = ~out_valid | out_ready.
  - All stage registers, including per-stage valid bits, advance only when en=1.
  - in_ready = en, combinational.
- Handshake rules:
  - A beat is accepted on an edge where in_valid & in_ready.
  - A result is consumed on an edge where out_valid & out_ready.
  - While out_valid=1 and out_ready=0, d/bout/ovf/out_valid hold stable and in_ready=0.
  - in_valid=0 with en=1 inserts a bubble; bubbles are not collapsed.
- Throughput: one beat per cycle when out_ready is held high.
- Ordering: results leave strictly in acceptance order; no beat is dropped or duplicated.
- Reset (rst_n=0, asynchronous):
  - All stage valid bits clear and out_valid=0.
  - d, bout and ovf are 0.
  - In-flight beats are discarded.
  - in_ready=1 one combinational path after reset.
- Reset mid-stream: beats accepted before reset never appear. The first result after reset release is from the first beat accepted after release.
- Data registers outside valid beats are don't-care internally. Outputs d/bout/ovf must still read 0 until the first out_valid.
- Boundary cases:
  - a=b, bin=0 gives d=0, bout=0.
  - a=0, b=0, bin=1 gives d=all-ones, bout=1.
  - b=all-ones, bin=1 gives bout=1 for every a.
- Simultaneous consume-and-accept on the same edge is legal and gives full throughput.

Test Plan:
- Basic: a=0x1234, b=0x0234, bin=0 -> after 4 cycles d=0x1000, bout=0, ovf=0.
- Wrap and borrow:
  - 0x0000-0x0001, bin=0 -> d=0xFFFF, bout=1, ovf=0.
  - a=0x0005, b=0x0003, bin=1 -> d=0x0001, bout=0.
- Overflow:
  - 0x8000-0x0001 -> d=0x7FFF, bout=0, ovf=1.
  - 0x7FFF-0xFFFF -> d=0x8000, bout=1, ovf=1.
- Streaming:
  - Drive 64 back-to-back beats with out_ready=1, using the incrementing patterns a+=0x0481 and b+=0x1021 with bin toggling.
  - Required: every result matches the reference model, in order; out_valid is continuous from cycle 4 to cycle 67.
- Backpressure: drop out_ready for 3 cycles mid-stream -> in_ready=0 and d/bout/ovf/out_valid stable during the stall, with no loss or duplication afterwards.
- Reset mid-operation:
  - Pulse rst_n low asynchronously (between edges) with 3 beats in flight.
  - Required: out_valid=0 immediately; none of the 3 beats ever emerges; a new beat 0x0010-0x0001 yields d=0x000F after 4 cycles.
